trigger_pulse_gen: RTL and testbench

- Output stage downstream of the fine-delay block.
- Converts the delayed single-cycle trigger pulse into a programmable output waveform: pulse width, burst count and burst period, all in clk cycles.
- Provides arming: single-shot or continuous operation, with holdoff against retriggering while busy.
- Reports status for host readback: busy, armed, trigger count and missed-trigger count.

---
 rtl/trigger_pulse_gen.sv | 185 ++++++++++++++++++
 tb/tb_trigger_pulse_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pulse_gen.sv
// trigger_pulse_gen: shapes the single-cycle trigger from the fine-delay chain
// into a programmable burst (width / period / count), with arming, retrigger
// holdoff and saturating status counters for host readback.
module trigger_pulse_gen #(
    parameter int WIDTH_BITS = 16,
    parameter int COUNT_BITS = 8,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger_in,
    input  logic [WIDTH_BITS-1:0] pulse_width,
    input  logic [WIDTH_BITS-1:0] pulse_period,
    input  logic [COUNT_BITS-1:0] burst_count,
    input  logic                  cfg_update,
    input  logic                  single_shot,
    input  logic                  arm,
    input  logic                  disarm,
    output logic                  trigger_out,
    output logic                  busy,
    output logic                  armed,
    output logic [STAT_BITS-1:0]  trig_count,
    output logic [STAT_BITS-1:0]  miss_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH_BITS-1:0] width;
        logic [WIDTH_BITS-1:0] period;
        logic [COUNT_BITS-1:0] count;
        logic                  single;
    } cfg_t;

    state_t                state_q, state_d;
    logic [WIDTH_BITS-1:0] el_q, el_d;          // cycles since current rising edge (1-based)
    logic [COUNT_BITS-1:0] left_q, left_d;      // pulses remaining, including the current one
    logic                  armed_q, armed_d;
    logic                  out_q, out_d;
    logic [STAT_BITS-1:0]  trig_q, trig_d;
    logic [STAT_BITS-1:0]  miss_q, miss_d;
    cfg_t                  shadow_q, shadow_d;
    cfg_t                  pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;

    cfg_t                  cfg_in;
    logic [WIDTH_BITS:0]   width_p1;
    logic [WIDTH_BITS-1:0] period_min;
    logic                  accept, miss, period_end, burst_end;

    // Sanitise the raw config inputs so a loaded burst always has width>=1,
    // count>=1 and at least one low cycle between pulses (unless width is saturated).
    always_comb begin
        cfg_in.width  = (pulse_width == '0) ? WIDTH_BITS'(1) : pulse_width;
        width_p1      = {1'b0, cfg_in.width} + {{WIDTH_BITS{1'b0}}, 1'b1};
        period_min    = width_p1[WIDTH_BITS] ? '1 : width_p1[WIDTH_BITS-1:0];
        cfg_in.period = (pulse_period < period_min) ? period_min : pulse_period;
        cfg_in.count  = (burst_count == '0) ? COUNT_BITS'(1) : burst_count;
        cfg_in.single = single_shot;
    end

    // Next-state logic: burst FSM, arming, shadow/pending config and status counters.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave
        // one unassigned and infer a latch.
        state_d      = state_q;
        el_d         = el_q;
        left_d       = left_q;
        armed_d      = armed_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        accept       = 1'b0;
        miss         = 1'b0;
        period_end   = 1'b0;
        burst_end    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trigger_in) begin
                    if (armed_q) begin
                        accept  = 1'b1;
                        state_d = HIGH;
                        el_d    = WIDTH_BITS'(1);
                        left_d  = shadow_q.count;
                    end else begin
                        miss = 1'b1;
                    end
                end
            end
            HIGH: begin
                miss = trigger_in;
                el_d = el_q + WIDTH_BITS'(1);
                if (el_q == shadow_q.width) begin
                    // Saturated width leaves period == width: no low phase at all.
                    if (el_q == shadow_q.period) period_end = 1'b1;
                    else                         state_d    = LOW;
                end
            end
            LOW: begin
                miss = trigger_in;
                el_d = el_q + WIDTH_BITS'(1);
                if (el_q == shadow_q.period) period_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (period_end) begin
            if (left_q > COUNT_BITS'(1)) begin
                state_d = HIGH;
                el_d    = WIDTH_BITS'(1);
                left_d  = left_q - COUNT_BITS'(1);
            end else begin
                state_d   = IDLE;
                burst_end = 1'b1;
            end
        end

        // Single-shot disarm at burst end takes priority, then disarm over arm.
        if (burst_end && shadow_q.single) armed_d = 1'b0;
        else if (disarm)                  armed_d = 1'b0;
        else if (arm)                     armed_d = 1'b1;

        // Config is applied directly in IDLE; during a burst it is parked until
        // the burst ends so a running burst never changes shape.
        if (cfg_update && state_q == IDLE) begin
            shadow_d = cfg_in;
        end else if (cfg_update) begin
            pend_d       = cfg_in;
            pend_valid_d = 1'b1;
        end
        if (burst_end) begin
            if (cfg_update)        shadow_d = cfg_in;
            else if (pend_valid_q) shadow_d = pend_q;
            pend_valid_d = 1'b0;
        end

        trig_d = (accept && !(&trig_q)) ? trig_q + STAT_BITS'(1) : trig_q;
        miss_d = (miss   && !(&miss_q)) ? miss_q + STAT_BITS'(1) : miss_q;
        out_d  = (state_d == HIGH);
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q         <= IDLE;
            el_q            <= '0;
            left_q          <= '0;
            armed_q         <= 1'b0;
            out_q           <= 1'b0;
            trig_q          <= '0;
            miss_q          <= '0;
            shadow_q.width  <= WIDTH_BITS'(1);
            shadow_q.period <= WIDTH_BITS'(2);
            shadow_q.count  <= COUNT_BITS'(1);
            shadow_q.single <= 1'b1;
            pend_q          <= '0;
            pend_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            el_q         <= el_d;
            left_q       <= left_d;
            armed_q      <= armed_d;
            out_q        <= out_d;
            trig_q       <= trig_d;
            miss_q       <= miss_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign trigger_out = out_q;
    assign busy        = (state_q != IDLE);
    assign armed       = armed_q;
    assign trig_count  = trig_q;
    assign miss_count  = miss_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen: a default-size instance for waveform,
// holdoff, config and reset behaviour, plus a narrow instance for width
// overflow and counter saturation.
module tb_trigger_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger_in, cfg_update, single_shot, arm, disarm;
    logic [15:0] pulse_width, pulse_period;
    logic [7:0]  burst_count;
    logic        trigger_out, busy, armed;
    logic [15:0] trig_count, miss_count;

    logic       s_trig, s_cfg, s_ss, s_arm, s_dis;
    logic [3:0] s_w, s_p;
    logic [1:0] s_c;
    logic       s_out, s_busy, s_armed;
    logic [3:0] s_tcnt, s_mcnt;

    int n_vec = 0;
    int n_err = 0;
    int exp_trig, exp_miss;
    logic [63:0] wv, bv, sw, sb;

    always #5 clk = ~clk;

    trigger_pulse_gen dut (
        .clk(clk), .rst(rst), .trigger_in(trigger_in),
        .pulse_width(pulse_width), .pulse_period(pulse_period),
        .burst_count(burst_count), .cfg_update(cfg_update),
        .single_shot(single_shot), .arm(arm), .disarm(disarm),
        .trigger_out(trigger_out), .busy(busy), .armed(armed),
        .trig_count(trig_count), .miss_count(miss_count)
    );

    trigger_pulse_gen #(.WIDTH_BITS(4), .COUNT_BITS(2), .STAT_BITS(4)) dut_s (
        .clk(clk), .rst(rst), .trigger_in(s_trig),
        .pulse_width(s_w), .pulse_period(s_p),
        .burst_count(s_c), .cfg_update(s_cfg),
        .single_shot(s_ss), .arm(s_arm), .disarm(s_dis),
        .trigger_out(s_out), .busy(s_busy), .armed(s_armed),
        .trig_count(s_tcnt), .miss_count(s_mcnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_cfg(input int w, input int p, input int c, input logic ss);
        pulse_width  = 16'(w);
        pulse_period = 16'(p);
        burst_count  = 8'(c);
        single_shot  = ss;
        cfg_update   = 1'b1;
        tick();
        cfg_update   = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Trigger for one cycle; returns at the first cycle where the output may be high.
    task automatic fire();
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
    endtask

    // Record trigger_out/busy for n cycles, optionally injecting triggers or cfg_update.
    task automatic capture(input int n, input logic [63:0] inj, input logic [63:0] cfgm,
                           output logic [63:0] w_o, output logic [63:0] b_o);
        w_o = '0;
        b_o = '0;
        for (int i = 0; i < n; i++) begin
            w_o[i]     = trigger_out;
            b_o[i]     = busy;
            trigger_in = inj[i];
            cfg_update = cfgm[i];
            tick();
        end
        trigger_in = 1'b0;
        cfg_update = 1'b0;
    endtask

    // Expected output: high for the first w cycles of each p-cycle slot, c slots.
    function automatic logic [63:0] exp_wave(input int w, input int p, input int c, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = (i < p * c) && ((i % p) < w);
        return r;
    endfunction

    function automatic logic [63:0] exp_busy(input int p, input int c, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = (i < p * c);
        return r;
    endfunction

    initial begin
        rst = 1'b0;
        trigger_in = 0; cfg_update = 0; single_shot = 0; arm = 0; disarm = 0;
        pulse_width = 0; pulse_period = 0; burst_count = 0;
        s_trig = 0; s_cfg = 0; s_ss = 0; s_arm = 0; s_dis = 0;
        s_w = 0; s_p = 0; s_c = 0;
        repeat (3) tick();

        check("rst_out",   trigger_out, 0);
        check("rst_busy",  busy, 0);
        check("rst_armed", armed, 0);
        check("rst_trig",  trig_count, 0);
        check("rst_miss",  miss_count, 0);
        rst = 1'b1;
        repeat (6) tick();

        // Default shadow config: width 1, period 2, count 1, single-shot.
        do_arm();
        fire();
        capture(4, 0, 0, wv, bv);
        check("dflt_wave",  wv, exp_wave(1, 2, 1, 4));
        check("dflt_busy",  bv, exp_busy(2, 1, 4));
        check("dflt_trig",  trig_count, 1);
        check("dflt_armed", armed, 0);

        // Continuous 4-pulse burst.
        do_cfg(3, 5, 4, 1'b0);
        do_arm();
        fire();
        capture(24, 0, 0, wv, bv);
        check("burst_wave",  wv, exp_wave(3, 5, 4, 24));
        check("burst_busy",  bv, exp_busy(5, 4, 24));
        check("burst_armed", armed, 1);
        check("burst_trig",  trig_count, 2);

        // All-zero config behaves like width 1, period 2, count 1.
        do_cfg(0, 0, 0, 1'b1);
        fire();
        capture(4, 0, 0, wv, bv);
        check("zero_wave",  wv, exp_wave(1, 2, 1, 4));
        check("zero_busy",  bv, exp_busy(2, 1, 4));
        check("zero_armed", armed, 0);

        // Period shorter than width+1 is raised to 11.
        do_cfg(10, 4, 1, 1'b0);
        do_arm();
        fire();
        capture(13, 0, 0, wv, bv);
        check("clamp_wave", wv, exp_wave(10, 11, 1, 13));
        check("clamp_busy", bv, exp_busy(11, 1, 13));
        check("clamp_trig", trig_count, 4);

        // Holdoff: two triggers while busy are counted as missed, waveform unchanged.
        do_cfg(2, 4, 3, 1'b0);
        do_arm();
        fire();
        capture(14, 64'h24, 0, wv, bv);
        check("hold_wave", wv, exp_wave(2, 4, 3, 14));
        check("hold_busy", bv, exp_busy(4, 3, 14));
        check("hold_miss", miss_count, 2);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        fire();
        capture(3, 0, 0, wv, bv);
        check("disarm_wave", wv, 0);
        check("disarm_miss", miss_count, 3);
        check("disarm_trig", trig_count, 5);

        // cfg_update mid-burst waits for the burst to finish.
        do_arm();
        pulse_width = 16'd7; pulse_period = 16'd4; burst_count = 8'd1; single_shot = 1'b0;
        fire();
        capture(14, 0, 64'h2, wv, bv);
        check("pend_old_wave", wv, exp_wave(2, 4, 3, 14));
        fire();
        capture(10, 0, 0, wv, bv);
        check("pend_new_wave", wv, exp_wave(7, 8, 1, 10));
        check("pend_new_busy", bv, exp_busy(8, 1, 10));
        check("pend_trig", trig_count, 7);
        check("pend_miss", miss_count, 3);

        // Trigger together with disarm in IDLE is still accepted.
        trigger_in = 1'b1;
        disarm     = 1'b1;
        tick();
        trigger_in = 1'b0;
        disarm     = 1'b0;
        check("trigdis_out",   trigger_out, 1);
        check("trigdis_armed", armed, 0);
        repeat (10) tick();
        check("trigdis_trig", trig_count, 8);

        // Reset in the middle of a HIGH phase.
        do_arm();
        fire();
        tick();
        check("prerst_out", trigger_out, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_out",   trigger_out, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_trig",  trig_count, 0);
        check("midrst_miss",  miss_count, 0);
        check("midrst_armed", armed, 0);
        tick();
        do_arm();
        fire();
        capture(4, 0, 0, wv, bv);
        check("postrst_wave", wv, exp_wave(1, 2, 1, 4));
        check("postrst_trig", trig_count, 1);

        // Narrow instance: width all-ones makes width+1 overflow, period becomes all-ones.
        s_w = 4'd15; s_p = 4'd0; s_c = 2'd0; s_ss = 1'b0;
        s_cfg = 1'b1; tick(); s_cfg = 1'b0;
        s_arm = 1'b1; tick(); s_arm = 1'b0;
        s_trig = 1'b1; tick(); s_trig = 1'b0;
        sw = '0;
        sb = '0;
        for (int i = 0; i < 17; i++) begin
            sw[i] = s_out;
            sb[i] = s_busy;
            tick();
        end
        check("ovf_wave", sw, exp_wave(15, 15, 1, 17));
        check("ovf_busy", sb, exp_busy(15, 1, 17));

        // Saturation: hold the trigger so every third cycle is accepted, the rest missed.
        s_w = 4'd1; s_p = 4'd0; s_c = 2'd1;
        s_cfg = 1'b1; tick(); s_cfg = 1'b0;
        s_trig = 1'b1;
        repeat (4) tick();
        check("sat_pre_trig", s_tcnt, 3);
        check("sat_pre_miss", s_mcnt, 2);
        repeat (60) tick();
        s_trig = 1'b0;
        check("sat_trig", s_tcnt, 15);
        check("sat_miss", s_mcnt, 15);
        repeat (4) tick();
        check("sat_armed", s_armed, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
